// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between the synchronous IROM and IF/ID.
// Define IFQ_BYPASS_EN to forward an IROM return straight to the head when the queue is empty.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IROM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               irom_en_o,
  output logic [IROM_AW-1:0] irom_addr_o,
  input  logic [31:0]        irom_rdata_i,
  output logic               fq_valid_o,
  input  logic               fq_ready_i,
  output logic [31:0]        fq_pc_o,
  output logic [31:0]        fq_pc4_o,
  output logic [31:0]        fq_instr_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic [CW:0]   w_occ;
  logic          w_issue, w_ret, w_buf_valid, w_push, w_pop;
  logic [31:0]   w_head_pc, w_head_instr;

  // Occupancy counts the in-flight word so a return always has a free slot.
  assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue     = !rst && !redirect_i && (w_occ < (CW+1)'(DEPTH));
  assign w_ret       = r_inflight && !redirect_i && !rst;
  assign w_buf_valid = (r_count != '0);
  assign w_pop       = w_buf_valid && fq_ready_i && !redirect_i && !rst;

  assign irom_en_o   = w_issue;
  assign irom_addr_o = r_fetch_pc[IROM_AW+1:2];

  always_comb begin
    fq_valid_o   = w_buf_valid;
    w_head_pc    = r_pc_mem[r_rd_ptr];
    w_head_instr = r_instr_mem[r_rd_ptr];
    w_push       = w_ret;
`ifdef IFQ_BYPASS_EN
    if (w_ret && !w_buf_valid) begin
      fq_valid_o   = 1'b1;
      w_head_pc    = r_inflight_pc;
      w_head_instr = irom_rdata_i;
      w_push       = !fq_ready_i;
    end
`endif
  end

  // Gate with valid so stale buffer contents never leak out after reset/flush.
  assign fq_pc_o    = fq_valid_o ? w_head_pc         : '0;
  assign fq_pc4_o   = fq_valid_o ? w_head_pc + 32'd4 : '0;
  assign fq_instr_o = fq_valid_o ? w_head_instr      : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= redirect_pc_i & ~32'h3;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
      r_instr_mem[r_wr_ptr] <= irom_rdata_i;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: IROM model plus a PC scoreboard checked on every handshake.
module tb_ifetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 14;

  logic          clk = 1'b0;
  logic          rst, redirect_i, fq_ready_i;
  logic [31:0]   redirect_pc_i, irom_rdata_i;
  logic          irom_en_o, fq_valid_o;
  logic [AW-1:0] irom_addr_o;
  logic [31:0]   fq_pc_o, fq_pc4_o, fq_instr_o;

  int checks = 0;
  int fails  = 0;
  int pops   = 0;
  int p0;
  logic [31:0] sb_pc [$];

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .IROM_AW(AW)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .irom_en_o(irom_en_o), .irom_addr_o(irom_addr_o), .irom_rdata_i(irom_rdata_i),
    .fq_valid_o(fq_valid_o), .fq_ready_i(fq_ready_i), .fq_pc_o(fq_pc_o),
    .fq_pc4_o(fq_pc4_o), .fq_instr_o(fq_instr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  always @(posedge clk) if (irom_en_o) irom_rdata_i <= rom(irom_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] start);
    sb_pc.delete();
    for (int i = 0; i < 64; i++) sb_pc.push_back(start + 32'(i) * 32'd4);
  endtask

  // One cycle: check any handshake against the scoreboard, then advance to the next negedge.
  task automatic step();
    logic [31:0] e;
    #1;
    if (fq_valid_o && fq_ready_i && !redirect_i && !rst) begin
      pops++;
      checks++;
      assert (sb_pc.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow observed=0x%08h expected=none", fq_pc_o);
      end
      if (sb_pc.size() != 0) begin
        e = sb_pc.pop_front();
        chk("pop_pc", fq_pc_o, e);
        chk("pop_pc4", fq_pc4_o, e + 32'd4);
        chk("pop_instr", fq_instr_o, rom(e[AW+1:2]));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; fq_ready_i = 1'b0;
    @(negedge clk);
    step(); step();
    #1;
    chk("rst_en", 32'(irom_en_o), 32'd0);
    chk("rst_valid", 32'(fq_valid_o), 32'd0);
    chk("rst_pc", fq_pc_o, 32'd0);
    chk("rst_pc4", fq_pc4_o, 32'd0);
    chk("rst_instr", fq_instr_o, 32'd0);

    // Streaming from reset
    sb_load(32'h0); fq_ready_i = 1'b1; rst = 1'b0;
    #1;
    chk("A_en_R", 32'(irom_en_o), 32'd1);
    chk("A_addr_R", 32'(irom_addr_o), 32'd0);
    step();
    #1;
    chk("A_addr_R1", 32'(irom_addr_o), 32'd1);
    chk("A_valid_R1", 32'(fq_valid_o), 32'd0);
    step();
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("A_valid_stream", 32'(fq_valid_o), 32'd1);
      chk("A_addr_seq", 32'(irom_addr_o), 32'(i + 2));
      step();
    end
    chk("A_pops", 32'(pops - p0), 32'd10);

    // Reset mid-operation, then stall from the start
    rst = 1'b1;
    step();
    #1;
    chk("B_rst_valid", 32'(fq_valid_o), 32'd0);
    chk("B_rst_en", 32'(irom_en_o), 32'd0);
    chk("B_rst_pc", fq_pc_o, 32'd0);
    chk("B_rst_pc4", fq_pc4_o, 32'd0);
    chk("B_rst_instr", fq_instr_o, 32'd0);
    fq_ready_i = 1'b0;
    step();
    sb_load(32'h0); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i >= 4) chk("B_full_no_issue", 32'(irom_en_o), 32'd0);
      if (i >= 2) chk("B_head_hold", fq_pc_o, 32'h0);
      step();
    end
    #1;
    chk("B_valid_full", 32'(fq_valid_o), 32'd1);
    chk("B_head_instr", fq_instr_o, rom(14'd0));
    fq_ready_i = 1'b1;
    p0 = pops;
    repeat (5) step();
    chk("B_release_pops", 32'(pops - p0), 32'd5);

    // Redirect to misaligned target while a fetch is in flight
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    #1;
    chk("C_en_N", 32'(irom_en_o), 32'd0);
    sb_load(32'h100);
    step();
    redirect_i = 1'b0;
    #1;
    chk("C_valid_N1", 32'(fq_valid_o), 32'd0);
    chk("C_en_N1", 32'(irom_en_o), 32'd1);
    chk("C_addr_N1", 32'(irom_addr_o), 32'h40);
    step();
    #1;
`ifdef IFQ_BYPASS_EN
    chk("C_valid_N2", 32'(fq_valid_o), 32'd1);
    chk("C_pc_N2", fq_pc_o, 32'h100);
`else
    chk("C_valid_N2", 32'(fq_valid_o), 32'd0);
`endif
    step();
    #1;
    chk("C_valid_N3", 32'(fq_valid_o), 32'd1);
    step();

    // Fill three entries, then redirect with ready high
    fq_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h280;
    sb_load(32'h280);
    step();
    redirect_i = 1'b0;
    repeat (4) step();
    #1;
    chk("D_head_before", fq_pc_o, 32'h280);
    redirect_i = 1'b1; redirect_pc_i = 32'h300; fq_ready_i = 1'b1;
    sb_load(32'h300);
    p0 = pops;
    step();
    redirect_i = 1'b0;
    #1;
    chk("D_empty_N1", 32'(fq_valid_o), 32'd0);
    step(); step(); step();
`ifdef IFQ_BYPASS_EN
    chk("D_pops", 32'(pops - p0), 32'd2);
`else
    chk("D_pops", 32'(pops - p0), 32'd1);
`endif

    // Fetch PC wraps through 0xFFFF_FFFC, then random back-pressure
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    sb_load(32'hFFFF_FFF8);
    step();
    redirect_i = 1'b0;
    #1; chk("E_addr_N1", 32'(irom_addr_o), 32'h3FFE);
    step();
    #1; chk("E_addr_N2", 32'(irom_addr_o), 32'h3FFF);
    step();
    #1; chk("E_addr_wrap", 32'(irom_addr_o), 32'h0);
    step();
    p0 = pops;
    for (int i = 0; i < 60; i++) begin
      fq_ready_i = 1'($urandom_range(0, 1));
      step();
    end
    chk("E_pops_min", 32'((pops - p0) >= 3 * DEPTH + 1), 32'd1);

    // Redirect-to-valid latency
    fq_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    sb_load(32'h200);
    step();
    redirect_i = 1'b0;
    #1; chk("F_valid_N1", 32'(fq_valid_o), 32'd0);
    step();
    #1;
`ifdef IFQ_BYPASS_EN
    chk("F_valid_N2", 32'(fq_valid_o), 32'd1);
    chk("F_pc_N2", fq_pc_o, 32'h200);
`else
    chk("F_valid_N2", 32'(fq_valid_o), 32'd0);
`endif
    step();
    #1; chk("F_valid_N3", 32'(fq_valid_o), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
